// File: rtl/alu_pkg.sv
// Purpose: shared opcode encodings and FSM state type for the ALU arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   ALU_ADD/ALU_SUB/ALU_MUL/ALU_NAND  opcode values understood by the shared ALU
//   arb_state_t                      arbiter FSM states
package alu_pkg;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_MUL  = 2;
  localparam int ALU_NAND = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin request picker; first asserted request at or after ptr, with wrap.
// Latency: combinational, zero cycles.
// Backpressure: en=0 forces an empty grant; the caller owns the pointer.
//
// Ports:
//   req      in   N    request vector
//   ptr      in   IW   highest-priority index for this decision (must be < N)
//   en       in   1    grant enable
//   gnt      out  N    one-hot (or zero) grant
//   gnt_idx  out  IW   index of the granted request, 0 when nothing is granted
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] w_cand;
  logic          w_found;

  // Walk the N candidates starting at ptr; the modulo keeps the search inside
  // 0..N-1, so indices >= N are never produced when N is not a power of two.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((32'(ptr) + 32'(k)) % 32'(N));
      if (en && !w_found && req[w_cand]) begin
        gnt[w_cand] = 1'b1;
        gnt_idx     = w_cand;
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: shares one combinational ALU between N_REQ requesters with round-robin grant.
// Latency: response k edges after accept (k=1, or MUL_CYCLES for MUL); issue interval k+2.
// Backpressure: response held in RESP until rsp_ready; no request is accepted meanwhile.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   req_valid/req_ready [N_REQ]   per-requester handshake; req_ready at most one-hot
//   req_opcode/op1/op2            packed per-requester operands, requester i at slice i
//   alu_opcode/op1/op2            registered operands to the shared ALU
//   alu_result                    combinational result from the shared ALU
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_result             owner index and captured result, stable while rsp_valid
//   busy                          high whenever the FSM is not IDLE
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RAM_WIDTH  = 32,
  parameter int WIDTH      = 2,
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_opcode,
  input  logic [N_REQ*RAM_WIDTH-1:0] req_op1,
  input  logic [N_REQ*RAM_WIDTH-1:0] req_op2,
  output logic [WIDTH-1:0]         alu_opcode,
  output logic [RAM_WIDTH-1:0]     alu_op1,
  output logic [RAM_WIDTH-1:0]     alu_op2,
  input  logic [RAM_WIDTH-1:0]     alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [RAM_WIDTH-1:0]     rsp_result,
  output logic                     busy
);

  // Counter holds MUL_CYCLES-1 at most.
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  arb_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_rsp_id;
  logic [WIDTH-1:0]     r_alu_opcode;
  logic [RAM_WIDTH-1:0] r_alu_op1;
  logic [RAM_WIDTH-1:0] r_alu_op2;
  logic [RAM_WIDTH-1:0] r_rsp_result;
  logic                 r_rsp_valid;

  logic [N_REQ-1:0]     w_gnt;
  logic [ID_W-1:0]      w_gnt_idx;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_sel_opcode;
  logic [RAM_WIDTH-1:0] w_sel_op1;
  logic [RAM_WIDTH-1:0] w_sel_op2;
  logic                 w_sel_is_mul;
  logic [ID_W-1:0]      w_next_ptr;

  // Grants only exist in IDLE, so req_ready is also the accept qualifier.
  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (r_state == IDLE),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |(req_valid & w_gnt);

  assign w_sel_opcode = req_opcode[w_gnt_idx*WIDTH +: WIDTH];
  assign w_sel_op1    = req_op1[w_gnt_idx*RAM_WIDTH +: RAM_WIDTH];
  assign w_sel_op2    = req_op2[w_gnt_idx*RAM_WIDTH +: RAM_WIDTH];
  assign w_sel_is_mul = (w_sel_opcode == WIDTH'(ALU_MUL));

  // Pointer moves to the requester after the winner; explicit wrap keeps it < N_REQ.
  assign w_next_ptr = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : (w_gnt_idx + ID_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rr_ptr     <= '0;
      r_rsp_id     <= '0;
      r_alu_opcode <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_rsp_result <= '0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_opcode <= w_sel_opcode;
            r_alu_op1    <= w_sel_op1;
            r_alu_op2    <= w_sel_op2;
            r_rsp_id     <= w_gnt_idx;
            r_rr_ptr     <= w_next_ptr;
            r_cnt        <= w_sel_is_mul ? CNT_W'(MUL_CYCLES - 1) : '0;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has been looking at the registered operands since the
          // accept edge; the extra MUL cycles give its multiplier time to settle.
          if (r_cnt == '0) begin
            r_rsp_result <= alu_result;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter with a behavioural shared ALU.
// Latency: responses checked against k=1 (k=MUL_CYCLES=3 for MUL) after accept.
// Backpressure: rsp_ready is stalled in one scenario; held outputs are watched.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int RW  = 32;
  localparam int OW  = 2;
  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int MC  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*OW-1:0]  req_opcode;
  logic [NR*RW-1:0]  req_op1;
  logic [NR*RW-1:0]  req_op2;
  logic [OW-1:0]     alu_opcode;
  logic [RW-1:0]     alu_op1;
  logic [RW-1:0]     alu_op2;
  logic [RW-1:0]     alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [RW-1:0]     rsp_result;
  logic              busy;

  logic [OW-1:0] t_op [NR];
  logic [RW-1:0] t_a  [NR];
  logic [RW-1:0] t_b  [NR];

  typedef struct {
    int          id;
    logic [31:0] res;
    int          k;
    int          c0;
  } exp_t;

  exp_t        sb[$];
  int          glog[$];
  int          gcyc[$];
  int          cyc;
  int          n_cmp;
  int          n_bad;
  int          viol;
  bit          rsp_open;
  logic [IW-1:0] hold_id;
  logic [RW-1:0] hold_res;
  logic [RW-1:0] last_res;
  int          last_id;
  int          last_lat;

  alu_arbiter #(
    .RAM_WIDTH  (RW),
    .WIDTH      (OW),
    .N_REQ      (NR),
    .ID_W       (IW),
    .MUL_CYCLES (MC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (int'(op))
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_MUL: return a * b;
      default: return ~(a & b);
    endcase
  endfunction

  // Behavioural shared ALU sitting next to the arbiter.
  always_comb alu_result = alu_f(alu_opcode, alu_op1, alu_op2);

  always_comb begin
    req_opcode = '0;
    req_op1    = '0;
    req_op2    = '0;
    for (int i = 0; i < NR; i++) begin
      req_opcode[i*OW +: OW] = t_op[i];
      req_op1[i*RW +: RW]    = t_a[i];
      req_op2[i*RW +: RW]    = t_b[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard push on accept, pop and compare on response.
  always @(negedge clk) begin
    logic [NR-1:0] acc;
    int            g;
    exp_t          e;
    if (!rst_n) begin
      sb.delete();
      rsp_open = 1'b0;
    end else begin
      if (!$onehot0(req_ready)) viol++;
      if (busy) check("ready_while_busy", 64'(req_ready), 64'd0);
      acc = req_valid & req_ready;
      if (acc != '0) begin
        g = 0;
        for (int i = 0; i < NR; i++) if (acc[i]) g = i;
        e.id  = g;
        e.res = alu_f(t_op[g], t_a[g], t_b[g]);
        e.k   = (int'(t_op[g]) == ALU_MUL) ? MC : 1;
        e.c0  = cyc;
        sb.push_back(e);
        glog.push_back(g);
        gcyc.push_back(cyc);
      end
      if (rsp_valid) begin
        if (!rsp_open) begin
          check("rsp_has_req", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            last_lat = cyc - e.c0 - 1;
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_result", 64'(rsp_result), 64'(e.res));
            check("rsp_latency", 64'(last_lat), 64'(e.k));
          end
          rsp_open = 1'b1;
          hold_id  = rsp_id;
          hold_res = rsp_result;
          last_res = rsp_result;
          last_id  = int'(rsp_id);
        end else begin
          check("hold_id", 64'(rsp_id), 64'(hold_id));
          check("hold_result", 64'(rsp_result), 64'(hold_res));
        end
        if (rsp_ready) rsp_open = 1'b0;
      end
    end
  end

  task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    t_op[id]      = op;
    t_a[id]       = x;
    t_b[id]       = y;
    req_valid[id] = 1'b1;
  endtask

  task automatic issue(input int id, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(id, op, x, y);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic await_grants(input int n);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (glog.size() >= n) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (!busy && !rsp_valid && sb.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    check("idle_reached", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb;
    bit seen;
    n_cmp = 0; n_bad = 0; viol = 0; cyc = 0;
    rsp_open = 1'b0; last_res = '0; last_id = 0; last_lat = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_op1", 64'(alu_op1), 64'd0);
    check("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin with all four requesters held valid: SUB 10-3
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) set_req(i, 2'(ALU_SUB), 32'd10, 32'd3);
    await_grants(5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    check("rr_g0", 64'(glog[0]), 64'd0);
    check("rr_g1", 64'(glog[1]), 64'd1);
    check("rr_g2", 64'(glog[2]), 64'd2);
    check("rr_g3", 64'(glog[3]), 64'd3);
    check("rr_g4", 64'(glog[4]), 64'd0);
    for (int i = 1; i < 5; i++) check("rr_interval", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
    check("rr_result", 64'(last_res), 64'd7);

    // Single ADD on requester 1
    issue(1, 2'(ALU_ADD), 32'd7, 32'd5);
    wait_idle();
    check("add_result", 64'(last_res), 64'd12);
    check("add_id", 64'(last_id), 64'd1);
    check("add_latency", 64'(last_lat), 64'd1);

    // MUL multicycle, then SUB wrap
    issue(2, 2'(ALU_MUL), 32'h0000_FFFF, 32'h0001_0001);
    wait_idle();
    check("mul_result", 64'(last_res), 64'hFFFF_FFFF);
    check("mul_latency", 64'(last_lat), 64'd3);
    issue(3, 2'(ALU_SUB), 32'd0, 32'd1);
    wait_idle();
    check("sub_result", 64'(last_res), 64'hFFFF_FFFF);
    check("sub_latency", 64'(last_lat), 64'd1);

    // Backpressure: response stalled while requesters 0 and 3 wait
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1, 2'(ALU_ADD), 32'd100, 32'd23);
    @(posedge clk); #1;
    set_req(0, 2'(ALU_ADD), 32'd1, 32'd2);
    set_req(3, 2'(ALU_NAND), 32'h1234_5678, 32'hFFFF_0000);
    gb = glog.size();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_rsp_seen", 64'(seen), 64'd1);
    repeat (5) @(negedge clk);
    check("bp_valid_held", 64'(rsp_valid), 64'd1);
    check("bp_result_held", 64'(rsp_result), 64'd123);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_no_grant", 64'(glog.size()), 64'(gb));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    await_grants(gb + 1);
    check("bp_next_grant", 64'(glog[gb]), 64'd3);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    await_grants(gb + 2);
    check("bp_after_grant", 64'(glog[gb+1]), 64'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle();
    check("bp_last_result", 64'(last_res), 64'd3);

    // NAND
    issue(2, 2'(ALU_NAND), 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_idle();
    check("nand_result", 64'(last_res), 64'h0FFF_0FFF);

    // Reset in the middle of a MUL
    issue(2, 2'(ALU_MUL), 32'd3, 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_alu_op1", 64'(alu_op1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    gb = glog.size();
    for (int i = 0; i < NR; i++) set_req(i, 2'(ALU_ADD), 32'(i), 32'd1);
    await_grants(gb + 1);
    check("midrst_first_grant", 64'(glog[gb]), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    check("midrst_result", 64'(last_res), 64'd1);

    check("ready_onehot0", 64'(viol), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
